cpu_checker_hex_field_parser: RTL and testbench
===============================================

Name: cpu_checker_hex_field_parser

Overview:
Streaming ASCII hex-field parser for the cpu_checker string pipeline. It consumes one character per accepted cycle and accumulates a run of hex digits into a binary value. It ends the field on the first non-hex character and reports the value, the digit count and the terminator. This is the parametrised, sequential successor to the single-character letter-to-nibble converter: it handles 0-9, a-f and optionally A-F, with configurable field length, length checking and overflow detection.

Parameters:
MAX_DIGITS, 8, maximum hex digits per field; VALUE_W = 4*MAX_DIGITS.
EXACT, 0, 1 = a field must contain exactly MAX_DIGITS digits, else error.
ALLOW_UPPER, 1, 1 = 'A'-'F' are digits; 0 = uppercase letters are non-hex (terminators).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
char_in  in  8  ASCII character.
char_valid  in  1  char_in is consumed this cycle when high.
flush  in  1  synchronous abort of the current field; has priority over char_valid.
value  out  VALUE_W  last successfully parsed value, zero-extended.
digit_cnt  out  $clog2(MAX_DIGITS+1)  digit count of the last completed field, including errored fields.
term_char  out  8  terminator character of the last completed field.
done  out  1  one-cycle pulse: field completed OK.
err  out  1  one-cycle pulse: field completed with error.
err_code  out  2  valid while err is high: 01 = overflow (more than MAX_DIGITS digits), 10 = length mismatch (EXACT only); 00 otherwise.
busy  out  1  high in DIGITS or SKIP.

Behaviour:
- Reset (async, reset_n=0):
  - value=0, digit_cnt=0, term_char=0, done=0, err=0, err_code=0, busy=0.
  - State = IDLE; internal accumulator and count cleared.
- Digit decode: '0'-'9' -> c-8'h30; 'a'-'f' -> c-8'h57; 'A'-'F' -> c-8'h37 when ALLOW_UPPER=1. Every other code is a terminator.
- Cycles with char_valid=0: no state change.
- FSM:
  - IDLE:
    - Valid digit -> acc = nibble, cnt = 1, go to DIGITS.
    - Valid non-hex -> ignored, stay in IDLE, no pulse.
  - DIGITS:
    - Valid digit with cnt < MAX_DIGITS -> acc = {acc[VALUE_W-5:0], nibble}, cnt+1.
    - Valid digit with cnt == MAX_DIGITS -> go to SKIP, overflow flag set.
    - Valid non-hex -> field ends. If EXACT=1 and cnt != MAX_DIGITS, it is an error with code 10. Otherwise it is OK: value = acc. Go to IDLE.
  - SKIP: digits are discarded. Valid non-hex -> err with code 01, go to IDLE.
- Outputs at field end:
  - done/err assert on the cycle after the terminating character's accepted edge and last exactly one cycle.
  - digit_cnt and term_char update on that same edge.
  - In SKIP, digit_cnt saturates at MAX_DIGITS.
  - value updates only on an OK field; on error it holds its previous value.
  - done and err are never high together.
- Back-to-back fields: the terminator is consumed by the ending field. A digit on the very next cycle starts a new field from IDLE, while done/err from the prior field pulse in that same cycle.
- flush=1: state goes to IDLE and acc/cnt are cleared. No done/err pulse. value, digit_cnt and term_char are held. Any pulse scheduled for this cycle still appears.
- No end-of-stream flush is implied: a field still open stays open until a terminator or flush arrives.
- Reset mid-field: the field is dropped and all outputs are cleared immediately (asynchronously).

Test Plan:
- Reset, then send "3000:" one char/cycle -> one cycle after ':' accepted: done=1, value=32'h00003000, digit_cnt=4, term_char=8'h3A, err=0.
- ALLOW_UPPER=1, send "aBcD#" with char_valid toggling 1,0,1,0... -> done once, value=32'h0000ABCD, digit_cnt=4, term_char='#'. Same stream with ALLOW_UPPER=0 -> done after 'B', value=32'h0000000A, term_char='B'. 'c' then starts a new field, giving value=32'h0000000C, term_char='D'.
- MAX_DIGITS=8, send "123456789@" -> err=1, err_code=01, digit_cnt=8, value unchanged from the prior field, done=0.
- EXACT=1, MAX_DIGITS=8, send "12#" then "deadbeef$" -> first field: err with err_code=10, digit_cnt=2. Second field: done, value=32'hDEADBEEF.
- Send "ff" then flush, then "1 " -> no pulse for "ff". Next field: done with value=1, term_char=8'h20.
- Mid-field after "12", drop reset_n to 0 for a partial cycle -> all outputs read 0 asynchronously. After release, "7:" -> done, value=7, digit_cnt=1.

Source files
------------

// File: rtl/cpu_checker_hex_field_parser.sv
// rtl/cpu_checker_hex_field_parser.sv - streaming ASCII hex-field parser with length/overflow checking
// Accumulates a run of hex digits and reports value, digit count and terminator at field end.
module cpu_checker_hex_field_parser #(
   parameter  int MAX_DIGITS  = 8,
   parameter  int EXACT       = 0,
   parameter  int ALLOW_UPPER = 1,
   localparam int VALUE_W     = 4 * MAX_DIGITS,
   localparam int CNT_W       = $clog2(MAX_DIGITS + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         char_in,
   input  logic               char_valid,
   input  logic               flush,
   output logic [VALUE_W-1:0] value,
   output logic [CNT_W-1:0]   digit_cnt,
   output logic [7:0]         term_char,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic               busy
);

   typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_SKIP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

   state_t             state_q, state_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [CNT_W-1:0]   digit_cnt_q, digit_cnt_d;
   logic [7:0]         term_q, term_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [1:0]         err_code_q, err_code_d;

   logic               is_hex;
   logic [3:0]         nibble;

   always_comb begin
      is_hex = 1'b0;
      nibble = 4'h0;
      if (char_in >= 8'h30 && char_in <= 8'h39) begin
         is_hex = 1'b1;
         nibble = 4'(char_in - 8'h30);
      end else if (char_in >= 8'h61 && char_in <= 8'h66) begin
         is_hex = 1'b1;
         nibble = 4'(char_in - 8'h57);
      end else if (ALLOW_UPPER != 0 && char_in >= 8'h41 && char_in <= 8'h46) begin
         is_hex = 1'b1;
         nibble = 4'(char_in - 8'h37);
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      value_d     = value_q;
      digit_cnt_d = digit_cnt_q;
      term_d      = term_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = 2'b00;
      if (flush) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (char_valid) begin
         case (state_q)
            S_IDLE: begin
               if (is_hex) begin
                  acc_d   = VALUE_W'(nibble);
                  cnt_d   = CNT_W'(1);
                  state_d = S_DIGITS;
               end
            end
            S_DIGITS: begin
               if (is_hex) begin
                  if (cnt_q == CNT_MAX) begin
                     state_d = S_SKIP;
                  end else begin
                     acc_d = (acc_q << 4) | VALUE_W'(nibble);
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  digit_cnt_d = cnt_q;
                  term_d      = char_in;
                  if (EXACT != 0 && cnt_q != CNT_MAX) begin
                     err_d      = 1'b1;
                     err_code_d = 2'b10;
                  end else begin
                     done_d  = 1'b1;
                     value_d = acc_q;
                  end
                  state_d = S_IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
               end
            end
            S_SKIP: begin
               // cnt stays at CNT_MAX while overflow digits are discarded
               if (!is_hex) begin
                  digit_cnt_d = CNT_MAX;
                  term_d      = char_in;
                  err_d       = 1'b1;
                  err_code_d  = 2'b01;
                  state_d     = S_IDLE;
                  acc_d       = '0;
                  cnt_d       = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         value_q     <= '0;
         digit_cnt_q <= '0;
         term_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         value_q     <= value_d;
         digit_cnt_q <= digit_cnt_d;
         term_q      <= term_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign value     = value_q;
   assign digit_cnt = digit_cnt_q;
   assign term_char = term_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpu_checker_hex_field_parser.sv
// tb/tb_cpu_checker_hex_field_parser.sv - randomized + directed bench for the hex-field parser
// Four parameterizations share one input stream and are checked against a field-level model.
module tb_cpu_checker_hex_field_parser;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] char_in;
   logic       char_valid;
   logic       flush;

   always #5 clk = ~clk;

   int MAXD[4] = '{8, 8, 8, 2};
   bit EXA[4]  = '{0, 0, 1, 0};
   bit UPP[4]  = '{1, 0, 1, 1};

   logic [31:0] dval[4];
   logic [31:0] dcnt[4];
   logic [7:0]  dterm[4];
   logic        ddone[4], derr[4], dbusy[4];
   logic [1:0]  dcode[4];

   logic [31:0] v0, v1, v2;
   logic [7:0]  v3;
   logic [3:0]  c0, c1, c2;
   logic [1:0]  c3;

   cpu_checker_hex_field_parser #(.MAX_DIGITS(8), .EXACT(0), .ALLOW_UPPER(1)) u0 (
      .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid), .flush(flush),
      .value(v0), .digit_cnt(c0), .term_char(dterm[0]), .done(ddone[0]), .err(derr[0]),
      .err_code(dcode[0]), .busy(dbusy[0]));
   cpu_checker_hex_field_parser #(.MAX_DIGITS(8), .EXACT(0), .ALLOW_UPPER(0)) u1 (
      .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid), .flush(flush),
      .value(v1), .digit_cnt(c1), .term_char(dterm[1]), .done(ddone[1]), .err(derr[1]),
      .err_code(dcode[1]), .busy(dbusy[1]));
   cpu_checker_hex_field_parser #(.MAX_DIGITS(8), .EXACT(1), .ALLOW_UPPER(1)) u2 (
      .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid), .flush(flush),
      .value(v2), .digit_cnt(c2), .term_char(dterm[2]), .done(ddone[2]), .err(derr[2]),
      .err_code(dcode[2]), .busy(dbusy[2]));
   cpu_checker_hex_field_parser #(.MAX_DIGITS(2), .EXACT(0), .ALLOW_UPPER(1)) u3 (
      .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid), .flush(flush),
      .value(v3), .digit_cnt(c3), .term_char(dterm[3]), .done(ddone[3]), .err(derr[3]),
      .err_code(dcode[3]), .busy(dbusy[3]));

   assign dval[0] = v0;
   assign dval[1] = v1;
   assign dval[2] = v2;
   assign dval[3] = {24'h0, v3};
   assign dcnt[0] = {28'h0, c0};
   assign dcnt[1] = {28'h0, c1};
   assign dcnt[2] = {28'h0, c2};
   assign dcnt[3] = {30'h0, c3};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Field-level model: collect digits of the open field, judge the whole field at its terminator.
   int          digs[4][$];
   bit          in_f[4];
   logic [31:0] m_val[4], m_cnt[4];
   logic [7:0]  m_term[4];
   bit          m_done[4], m_err[4];
   logic [1:0]  m_code[4];

   function automatic int dec(logic [7:0] c, bit upp);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (upp && c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
   endfunction

   task automatic model_step(int k);
      int d, n;
      logic [63:0] v;
      m_done[k] = 0;
      m_err[k]  = 0;
      m_code[k] = 2'b00;
      if (flush) begin
         digs[k].delete();
         in_f[k] = 0;
      end else if (char_valid) begin
         d = dec(char_in, UPP[k]);
         if (d >= 0) begin
            digs[k].push_back(d);
            in_f[k] = 1;
         end else if (in_f[k]) begin
            n = digs[k].size();
            m_term[k] = char_in;
            if (n > MAXD[k]) begin
               m_err[k] = 1; m_code[k] = 2'b01; m_cnt[k] = MAXD[k];
            end else if (EXA[k] && n != MAXD[k]) begin
               m_err[k] = 1; m_code[k] = 2'b10; m_cnt[k] = n;
            end else begin
               v = 0;
               foreach (digs[k][i]) v = v * 16 + 64'(digs[k][i]);
               m_done[k] = 1; m_val[k] = v[31:0]; m_cnt[k] = n;
            end
            digs[k].delete();
            in_f[k] = 0;
         end
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            digs[k].delete();
            in_f[k] = 0; m_val[k] = 0; m_cnt[k] = 0; m_term[k] = 0;
            m_done[k] = 0; m_err[k] = 0; m_code[k] = 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) model_step(k);
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("u%0d.done", k), 64'(ddone[k]), 64'(m_done[k]));
            chk($sformatf("u%0d.err", k), 64'(derr[k]), 64'(m_err[k]));
            chk($sformatf("u%0d.err_code", k), 64'(dcode[k]), 64'(m_code[k]));
            chk($sformatf("u%0d.value", k), 64'(dval[k]), 64'(m_val[k]));
            chk($sformatf("u%0d.digit_cnt", k), 64'(dcnt[k]), 64'(m_cnt[k]));
            chk($sformatf("u%0d.term_char", k), 64'(dterm[k]), 64'(m_term[k]));
            chk($sformatf("u%0d.busy", k), 64'(dbusy[k]), 64'(in_f[k]));
         end
      end
   end

   task automatic drive(logic [7:0] c, logic v, logic f);
      char_in    = c;
      char_valid = v;
      flush      = f;
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(string s);
      for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
   endtask

   task automatic chk_zero_outputs(string tag);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s.u%0d.value", tag, k), 64'(dval[k]), 64'h0);
         chk($sformatf("%s.u%0d.cnt_term", tag, k), 64'({dcnt[k], dterm[k]}), 64'h0);
         chk($sformatf("%s.u%0d.flags", tag, k), 64'({ddone[k], derr[k], dcode[k], dbusy[k]}), 64'h0);
      end
   endtask

   logic [7:0] terms[6] = '{8'h3A, 8'h20, 8'h23, 8'h24, 8'h40, 8'h0A};
   string      s_abcd = "aBcD#";

   initial begin
      int r;
      logic [7:0] c;
      reset_n = 1'b0; char_in = 8'h00; char_valid = 1'b0; flush = 1'b0;
      #3;
      chk_zero_outputs("reset");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      send_str("3000:");
      chk("t1.done", 64'(ddone[0]), 64'h1);
      chk("t1.err", 64'(derr[0]), 64'h0);
      chk("t1.value", 64'(dval[0]), 64'h3000);
      chk("t1.cnt", 64'(dcnt[0]), 64'h4);
      chk("t1.term", 64'(dterm[0]), 64'h3A);
      chk("t1.model_value", 64'(m_val[0]), 64'h3000);
      drive(8'h00, 1'b0, 1'b0);

      for (int i = 0; i < s_abcd.len(); i++) begin
         drive(s_abcd[i], 1'b1, 1'b0);
         if (i == 1) begin
            chk("t2.lower_done", 64'(ddone[1]), 64'h1);
            chk("t2.lower_value", 64'(dval[1]), 64'hA);
            chk("t2.lower_term", 64'(dterm[1]), 64'h42);
         end
         if (i == 3) begin
            chk("t2.lower_value2", 64'(dval[1]), 64'hC);
            chk("t2.lower_term2", 64'(dterm[1]), 64'h44);
         end
         if (i == 4) begin
            chk("t2.upper_done", 64'(ddone[0]), 64'h1);
            chk("t2.upper_value", 64'(dval[0]), 64'hABCD);
            chk("t2.upper_term", 64'(dterm[0]), 64'h23);
            chk("t2.model_value", 64'(m_val[0]), 64'hABCD);
         end
         drive(8'h35, 1'b0, 1'b0);
      end

      send_str("123456789@");
      chk("t3.err", 64'(derr[0]), 64'h1);
      chk("t3.code", 64'(dcode[0]), 64'h1);
      chk("t3.cnt", 64'(dcnt[0]), 64'h8);
      chk("t3.value_held", 64'(dval[0]), 64'hABCD);
      chk("t3.done", 64'(ddone[0]), 64'h0);

      send_str("12#");
      chk("t4.err", 64'(derr[2]), 64'h1);
      chk("t4.code", 64'(dcode[2]), 64'h2);
      chk("t4.cnt", 64'(dcnt[2]), 64'h2);
      send_str("deadbeef$");
      chk("t4.done", 64'(ddone[2]), 64'h1);
      chk("t4.value", 64'(dval[2]), 64'hDEADBEEF);
      chk("t4.model_value", 64'(m_val[2]), 64'hDEADBEEF);

      send_str("ff");
      drive(8'h31, 1'b1, 1'b1);
      chk("t5.flush_busy", 64'(dbusy[0]), 64'h0);
      send_str("1 ");
      chk("t5.done", 64'(ddone[0]), 64'h1);
      chk("t5.value", 64'(dval[0]), 64'h1);
      chk("t5.term", 64'(dterm[0]), 64'h20);

      send_str("12");
      chk("t6.busy_before", 64'(dbusy[0]), 64'h1);
      #1 reset_n = 1'b0;
      #1 chk_zero_outputs("midreset");
      #1 reset_n = 1'b1;
      send_str("7:");
      chk("t6.done", 64'(ddone[0]), 64'h1);
      chk("t6.value", 64'(dval[0]), 64'h7);
      chk("t6.cnt", 64'(dcnt[0]), 64'h1);

      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 30)      c = 8'h30 + 8'($urandom_range(0, 9));
         else if (r < 50) c = 8'h61 + 8'($urandom_range(0, 5));
         else if (r < 65) c = 8'h41 + 8'($urandom_range(0, 5));
         else if (r < 75) c = 8'h47 + 8'($urandom_range(0, 19));
         else             c = terms[$urandom_range(0, 5)];
         drive(c, ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 2));
      end
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
